mux16_scan_ctrl: RTL and testbench

MUX16_SCAN_CTRL -- requirements
Module: mux16_scan_ctrl

---
 rtl/mux16_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_mux16_scan_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux16_scan_ctrl.sv
// Scans a 2**SELW:1 mux by stepping sel from 0 to a latched last_sel, packing
// each sampled mux_op bit into out_data and presenting the word with valid/ready.
module mux16_scan_ctrl #(
  parameter int WIDTH = 16,
  parameter int SELW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SELW-1:0] last_sel,
  input  logic            mux_op,
  output logic [SELW-1:0] sel,
  output logic            busy,
  output logic [WIDTH-1:0] out_data,
  output logic [SELW:0]   ones_cnt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      dbg_state
);

  // Handshake: a word transfers on a rising edge where out_valid && out_ready.
  // out_valid stays high and out_data/ones_cnt/sel stay frozen until then.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [SELW:0] CNT_MAX = (SELW+1)'(WIDTH);

  state_e           state_q, state_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [SELW-1:0]  last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW:0]    cnt_q, cnt_d;
  logic             settle_q, settle_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             accept;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    accept   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sel_d = '0;
        if (start) accept = 1'b1;
      end
      ST_SCAN: begin
        // The first SCAN cycle lets the mux settle after sel jumps back to 0.
        if (settle_q) begin
          settle_d = 1'b0;
        end else begin
          data_d[sel_q] = mux_op;
          if (mux_op && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
          if (sel_q == last_q) state_d = ST_HOLD;
          else sel_d = sel_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (start) begin
            accept = 1'b1;
          end else begin
            state_d = ST_IDLE;
            sel_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase

    if (accept) begin
      state_d  = ST_SCAN;
      last_d   = last_sel;
      data_d   = '0;
      cnt_d    = '0;
      sel_d    = '0;
      settle_d = 1'b1;
    end

    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      last_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      settle_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign sel       = sel_q;
  assign busy      = busy_q;
  assign out_data  = data_q;
  assign ones_cnt  = cnt_q;
  assign out_valid = valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Bench for mux16_scan_ctrl: a behavioural 16:1 mux drives mux_op, expected words
// come from masking the mux pattern to the scanned range and counting ones.
module tb_mux16_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  last_sel = '0;
  logic        mux_op;
  logic [3:0]  sel;
  logic        busy;
  logic [15:0] out_data;
  logic [4:0]  ones_cnt;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  dbg_state;

  logic [15:0] mux_in = '0;
  logic [15:0] exp_q[$];
  logic [15:0] last_exp = '0;
  logic [3:0]  cur_last = '0;
  int          errors = 0;
  int          checks = 0;
  bit          in_hold = 0;

  mux16_scan_ctrl #(.WIDTH(16), .SELW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .last_sel(last_sel),
    .mux_op(mux_op), .sel(sel), .busy(busy), .out_data(out_data),
    .ones_cnt(ones_cnt), .out_valid(out_valid), .out_ready(out_ready),
    .dbg_state(dbg_state)
  );

  // Behavioural mux the controller is scanning.
  assign mux_op = mux_in[sel];

  always #5 clk = ~clk;

  function automatic logic [15:0] mask_of(input logic [3:0] last);
    logic [16:0] m;
    m = (17'd1 << (int'(last) + 1)) - 17'd1;
    return m[15:0];
  endfunction

  task automatic kick(input logic [15:0] pat, input logic [3:0] last, input bit with_ready);
    mux_in = pat; last_sel = last; start = 1'b1; out_ready = with_ready;
    cur_last = last;
    exp_q.push_back(pat & mask_of(last));
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b0; last_sel = 4'($urandom);
    in_hold = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL kick_busy got=%b exp=1", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL kick_valid got=%b exp=0", out_valid); end
    checks++; if (sel !== 4'd0) begin errors++; $display("FAIL kick_sel got=%0d exp=0", sel); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL kick_data got=%h exp=0000", out_data); end
    checks++; if (ones_cnt !== 5'd0) begin errors++; $display("FAIL kick_ones got=%0d exp=0", ones_cnt); end
  endtask

  task automatic wait_result(input bit noise, input string name);
    int k;
    int prev;
    bit seen;
    logic [15:0] exp_w;
    exp_w = exp_q.pop_front();
    k = 0; prev = 0; seen = 0;
    while (k < 40 && !seen) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        last_sel = 4'($urandom);
        out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      k++;
      checks++;
      if (int'(sel) < prev || int'(sel) > prev + 1 || sel > cur_last) begin
        errors++; $display("FAIL %s_sel_step got=%0d prev=%0d last=%0d", name, sel, prev, cur_last);
      end
      prev = int'(sel);
      seen = out_valid;
    end
    start = 1'b0; out_ready = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL %s_timeout got=no_valid exp=valid", name); end
    checks++; if (k !== int'(cur_last) + 2) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, k, int'(cur_last) + 2); end
    checks++; if (out_data !== exp_w) begin errors++; $display("FAIL %s_data got=%h exp=%h", name, out_data, exp_w); end
    checks++; if (ones_cnt !== 5'($countones(exp_w))) begin errors++; $display("FAIL %s_ones got=%0d exp=%0d", name, ones_cnt, $countones(exp_w)); end
    checks++; if (sel !== cur_last) begin errors++; $display("FAIL %s_hold_sel got=%0d exp=%0d", name, sel, cur_last); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_hold_busy got=%b exp=1", name, busy); end
    last_exp = exp_w;
    in_hold = 1;
  endtask

  task automatic hold_check(input int n);
    for (int c = 0; c < n; c++) begin
      out_ready = 1'b0; start = 1'($urandom_range(0, 1)); last_sel = 4'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== last_exp || sel !== cur_last) begin
        errors++; $display("FAIL hold_stable got=v%b d%h s%0d exp=v1 d%h s%0d", out_valid, out_data, sel, last_exp, cur_last);
      end
    end
    start = 1'b0;
  endtask

  task automatic release_word();
    out_ready = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_hold = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy got=%b exp=0", busy); end
    checks++; if (sel !== 4'd0) begin errors++; $display("FAIL release_sel got=%0d exp=0", sel); end
    checks++; if (out_data !== last_exp) begin errors++; $display("FAIL release_data got=%h exp=%h", out_data, last_exp); end
    checks++; if (ones_cnt !== 5'($countones(last_exp))) begin errors++; $display("FAIL release_ones got=%0d exp=%0d", ones_cnt, $countones(last_exp)); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || sel !== 4'd0 || out_data !== 16'h0 || ones_cnt !== 5'd0) begin
      errors++; $display("FAIL reset_outputs got=b%b v%b s%0d d%h o%0d exp=all_zero", busy, out_valid, sel, out_data, ones_cnt);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_full_scan();
    kick(16'hA5C3, 4'd15, 1'b0);
    wait_result(1'b0, "full");
    release_word();
  endtask

  task automatic test_partial_scan();
    kick(16'hFFFF, 4'd3, 1'b0);
    wait_result(1'b0, "partial");
    release_word();
  endtask

  task automatic test_single_bit();
    kick(16'($urandom) | 16'h0001, 4'd0, 1'b0);
    wait_result(1'b0, "single");
    release_word();
  endtask

  task automatic test_backpressure();
    kick(16'($urandom), 4'd9, 1'b0);
    wait_result(1'b0, "bp");
    hold_check(10);
    release_word();
  endtask

  task automatic test_back_to_back();
    kick(16'hFFFF, 4'd15, 1'b0);
    wait_result(1'b0, "b2b_first");
    kick(16'h0001, 4'd15, 1'b1);
    wait_result(1'b0, "b2b_second");
    release_word();
  endtask

  task automatic test_ignored();
    kick(16'h3C5A, 4'd5, 1'b0);
    wait_result(1'b1, "ignored");
    release_word();
  endtask

  task automatic test_reset_mid_scan();
    bit hit;
    kick(16'hFFFF, 4'd15, 1'b0);
    exp_q.delete();
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(posedge clk); #1;
      hit = (sel == 4'd7);
    end
    checks++; if (!hit) begin errors++; $display("FAIL midrst_reach got=%0d exp=7", sel); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || sel !== 4'd0 || out_data !== 16'h0 || ones_cnt !== 5'd0) begin
      errors++; $display("FAIL midrst_async got=b%b v%b s%0d d%h o%0d exp=all_zero", busy, out_valid, sel, out_data, ones_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL midrst_quiet got=v%b b%b exp=v0 b0", out_valid, busy);
      end
    end
    in_hold = 0;
  endtask

  task automatic test_first_start_after_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    kick(16'h8001, 4'd15, 1'b0);
    wait_result(1'b0, "post_reset");
    release_word();
  endtask

  task automatic test_random();
    logic [15:0] pat;
    logic [3:0]  last;
    for (int it = 0; it < 30; it++) begin
      pat = 16'($urandom);
      last = 4'($urandom_range(0, 15));
      if (in_hold && $urandom_range(0, 1) == 1) begin
        kick(pat, last, 1'b1);
      end else begin
        if (in_hold) release_word();
        kick(pat, last, 1'b0);
      end
      wait_result(1'($urandom_range(0, 1)), "random");
      hold_check($urandom_range(0, 3));
    end
    if (in_hold) release_word();
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_partial_scan();
    test_single_bit();
    test_backpressure();
    test_back_to_back();
    test_ignored();
    test_reset_mid_scan();
    test_first_start_after_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
